// File: rtl/obi_data_mem_resp.sv
// ---------------------------------------------------------------------------
// obi_data_mem_resp
//   OBI-style data-memory responder for the core LSU data port. It accepts one
//   transaction per cycle through a req/gnt handshake and returns exactly one
//   response per accepted transaction, in order, a fixed number of cycles later.
//   Writes use per-byte enables. An address beyond the memory depth gives an
//   error response and does not modify memory. Grant is withheld when the
//   outstanding-transaction limit is reached. It can also be withheld for one
//   cycle after every GNT_STALL_PERIOD accepts.
//
// Ports
//   clk            clock, rising edge
//   rst            asynchronous active-high reset
//   data_req_i     LSU request
//   data_we_i      1 = write, 0 = read
//   data_be_i      byte enables (writes only)
//   data_addr_i    byte address (low log2(DATA_WIDTH/8) bits ignored)
//   data_wdata_i   write data
//   data_gnt_o     grant, combinational
//   data_rvalid_o  response valid, one cycle per accepted transaction
//   data_rdata_o   read data (0 for writes and out-of-range reads), held when idle
//   data_err_o     address out of range, qualified by data_rvalid_o, held when idle
// ---------------------------------------------------------------------------
module obi_data_mem_resp #(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDR_WIDTH       = 32,
  parameter int DEPTH_WORDS      = 1024,
  parameter int RSP_LATENCY      = 1,
  parameter int MAX_OUTSTANDING  = 2,
  parameter int GNT_STALL_PERIOD = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    data_req_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    data_err_o
);

  localparam int BE_W   = DATA_WIDTH / 8;
  localparam int OFFS   = (BE_W > 1) ? $clog2(BE_W) : 0;
  localparam int IDX_W  = ADDR_WIDTH - OFFS;
  localparam int MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0]  word_idx;
  logic [MEM_AW-1:0] mem_idx;
  logic              in_range;

  assign word_idx = data_addr_i[ADDR_WIDTH-1:OFFS];
  assign mem_idx  = word_idx[MEM_AW-1:0];
  // One extra bit so DEPTH_WORDS itself is representable in the compare.
  assign in_range = ({1'b0, word_idx} < (IDX_W + 1)'(DEPTH_WORDS));

  generate
    if (OFFS > 0) begin : g_lsb
      // Byte offset inside a word carries no meaning for this memory.
      logic addr_lsb_unused;
      assign addr_lsb_unused = ^data_addr_i[OFFS-1:0];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Handshake: outstanding limit and periodic stall
  // ---------------------------------------------------------------------------
  logic             rsp_valid;
  logic             stall;
  logic             accept;
  logic             slot_free;
  logic [CNT_W-1:0] outstanding_reg;
  logic [CNT_W-1:0] outstanding_eff;
  logic [CNT_W-1:0] outstanding_next;

  // A response leaving this cycle frees its slot immediately, so grant can
  // reopen in the same cycle rvalid is high.
  assign outstanding_eff  = outstanding_reg - CNT_W'(rsp_valid);
  assign slot_free        = (outstanding_eff < CNT_W'(MAX_OUTSTANDING));
  assign data_gnt_o       = data_req_i & ~rst & slot_free & ~stall;
  assign accept           = data_gnt_o;
  assign outstanding_next = outstanding_eff + CNT_W'(accept);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding_reg <= '0;
    end else begin
      outstanding_reg <= outstanding_next;
    end
  end

  generate
    if (GNT_STALL_PERIOD > 0) begin : g_stall
      localparam int SW = (GNT_STALL_PERIOD > 1) ? $clog2(GNT_STALL_PERIOD) : 1;
      logic [SW-1:0] stall_cnt_reg;
      logic          stall_reg;

      // The Nth accept arms a one-cycle stall; grant is low during that cycle,
      // so no accept can re-arm it and the stall lasts exactly one cycle.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          stall_cnt_reg <= '0;
          stall_reg     <= 1'b0;
        end else if (accept) begin
          if (stall_cnt_reg == SW'(GNT_STALL_PERIOD - 1)) begin
            stall_cnt_reg <= '0;
            stall_reg     <= 1'b1;
          end else begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
            stall_reg     <= 1'b0;
          end
        end else begin
          stall_reg <= 1'b0;
        end
      end

      assign stall = stall_reg;
    end else begin : g_no_stall
      assign stall = 1'b0;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Memory: one byte-wide array per lane, registered read on read accepts
  // ---------------------------------------------------------------------------
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] mem_q;

  assign wr_en = accept & data_we_i & in_range;
  assign rd_en = accept & ~data_we_i & in_range;

  genvar gi;
  generate
    for (gi = 0; gi < BE_W; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH_WORDS];
      logic [7:0] lane_q_reg;

      always_ff @(posedge clk) begin
        if (wr_en && data_be_i[gi]) begin
          lane_mem[mem_idx] <= data_wdata_i[gi*8 +: 8];
        end
        if (rd_en) begin
          lane_q_reg <= lane_mem[mem_idx];
        end
      end

      assign mem_q[gi*8 +: 8] = lane_q_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Response stage 1: formed at the accept edge. The read register only loads
  // on in-range reads, so zero_reg masks it for writes and errors, and all
  // stage-1 values hold between accepts.
  // ---------------------------------------------------------------------------
  logic                  s1_valid_reg;
  logic                  s1_zero_reg;
  logic                  s1_err_reg;
  logic [DATA_WIDTH-1:0] s1_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_zero_reg  <= 1'b1;
      s1_err_reg   <= 1'b0;
    end else begin
      s1_valid_reg <= accept;
      if (accept) begin
        s1_zero_reg <= data_we_i | ~in_range;
        s1_err_reg  <= ~in_range;
      end
    end
  end

  assign s1_rdata = s1_zero_reg ? '0 : mem_q;

  // ---------------------------------------------------------------------------
  // Remaining RSP_LATENCY-1 stages. Data/err only advance behind a valid entry
  // so the output registers keep the last response while rvalid is low.
  // ---------------------------------------------------------------------------
  generate
    if (RSP_LATENCY <= 1) begin : g_lat1
      assign rsp_valid    = s1_valid_reg;
      assign data_rdata_o = s1_rdata;
      assign data_err_o   = s1_err_reg;
    end else begin : g_pipe
      localparam int NS = RSP_LATENCY - 1;
      logic [NS-1:0]         v_reg;
      logic [NS-1:0]         e_reg;
      logic [DATA_WIDTH-1:0] d_reg [NS];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v_reg <= '0;
          e_reg <= '0;
          for (int i = 0; i < NS; i++) begin
            d_reg[i] <= '0;
          end
        end else begin
          v_reg[0] <= s1_valid_reg;
          if (s1_valid_reg) begin
            d_reg[0] <= s1_rdata;
            e_reg[0] <= s1_err_reg;
          end
          for (int i = 1; i < NS; i++) begin
            v_reg[i] <= v_reg[i-1];
            if (v_reg[i-1]) begin
              d_reg[i] <= d_reg[i-1];
              e_reg[i] <= e_reg[i-1];
            end
          end
        end
      end

      assign rsp_valid    = v_reg[NS-1];
      assign data_rdata_o = d_reg[NS-1];
      assign data_err_o   = e_reg[NS-1];
    end
  endgenerate

  assign data_rvalid_o = rsp_valid;

endmodule
